// File: rtl/alu_result_checker_if.sv
// Operand/select stream feeding the ALU plus the ALU's registered response,
// bundled so a checker can sit beside the ALU on one port.
interface alu_result_checker_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] dut_result;
    logic             dut_ov;

    modport master (
        output in_valid, in_a, in_b, in_sel, dut_result, dut_ov
    );

    modport slave (
        input in_valid, in_a, in_b, in_sel, dut_result, dut_ov
    );
endinterface

// File: rtl/alu_result_checker.sv
// Response-side ALU checker: predicts result/overflow, aligns the prediction to the
// ALU's latency, compares, and keeps saturating counters plus a first-mismatch capture.
module alu_result_checker #(
    parameter int WIDTH       = 32,
    parameter int LAT         = 1,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    alu_result_checker_if.slave  bus,
    output logic [CNT_W-1:0]     chk_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 err_flag,
    output logic [1:0]           state,
    output logic [2:0]           first_err_sel,
    output logic [WIDTH-1:0]     first_err_expected,
    output logic [WIDTH-1:0]     first_err_actual
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {overflow, result}; overflow is only meaningful for add/sub.
    function automatic logic [WIDTH:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        logic             ov;
        r  = {WIDTH{1'b0}};
        ov = 1'b0;
        case (sel)
            3'b000: begin
                r  = a + b;
                ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                r  = a - b;
                ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a | b);
            3'b110:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b111:  r = b << a[4:0];
            default: r = {WIDTH{1'b0}};
        endcase
        return {ov, r};
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH:0]   model_s;
    logic             cmp_valid_s;
    logic [2:0]       cmp_sel_s;
    logic [WIDTH-1:0] cmp_exp_s;
    logic             cmp_ov_s;
    logic             cmp_en_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] chk_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic             err_flag_r;
    logic [2:0]       first_err_sel_r;
    logic [WIDTH-1:0] first_err_expected_r;
    logic [WIDTH-1:0] first_err_actual_r;

    assign model_s = alu_model(bus.in_a, bus.in_b, bus.in_sel);

    if (LAT > 0) begin : g_dly
        logic             stg_valid_r [LAT];
        logic [2:0]       stg_sel_r   [LAT];
        logic [WIDTH-1:0] stg_exp_r   [LAT];
        logic             stg_ov_r    [LAT];

        // Prediction delay line; a clear drops every in-flight sample.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LAT; i++) begin
                    stg_valid_r[i] <= 1'b0;
                    stg_sel_r[i]   <= 3'b000;
                    stg_exp_r[i]   <= {WIDTH{1'b0}};
                    stg_ov_r[i]    <= 1'b0;
                end
            end else if (clear) begin
                for (int i = 0; i < LAT; i++) begin
                    stg_valid_r[i] <= 1'b0;
                    stg_sel_r[i]   <= 3'b000;
                    stg_exp_r[i]   <= {WIDTH{1'b0}};
                    stg_ov_r[i]    <= 1'b0;
                end
            end else begin
                stg_valid_r[0] <= bus.in_valid;
                stg_sel_r[0]   <= bus.in_sel;
                stg_exp_r[0]   <= model_s[WIDTH-1:0];
                stg_ov_r[0]    <= model_s[WIDTH];
                for (int i = 1; i < LAT; i++) begin
                    stg_valid_r[i] <= stg_valid_r[i-1];
                    stg_sel_r[i]   <= stg_sel_r[i-1];
                    stg_exp_r[i]   <= stg_exp_r[i-1];
                    stg_ov_r[i]    <= stg_ov_r[i-1];
                end
            end
        end

        assign cmp_valid_s = stg_valid_r[LAT-1];
        assign cmp_sel_s   = stg_sel_r[LAT-1];
        assign cmp_exp_s   = stg_exp_r[LAT-1];
        assign cmp_ov_s    = stg_ov_r[LAT-1];
    end else begin : g_nodly
        assign cmp_valid_s = bus.in_valid;
        assign cmp_sel_s   = bus.in_sel;
        assign cmp_exp_s   = model_s[WIDTH-1:0];
        assign cmp_ov_s    = model_s[WIDTH];
    end

    // FAIL freezes everything, so compares are simply disabled there.
    assign cmp_en_s   = cmp_valid_s && (state_r != ST_FAIL);
    assign mismatch_s = (bus.dut_result != cmp_exp_s) || (bus.dut_ov != cmp_ov_s);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmp_en_s) begin
                    if (mismatch_s && STOP_ON_ERR) begin
                        state_nx_s = ST_FAIL;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmp_en_s && mismatch_s && STOP_ON_ERR) begin
                    state_nx_s = ST_FAIL;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FAIL: state_nx_s = ST_FAIL;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Saturating counters and first-mismatch capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_count_r          <= {CNT_W{1'b0}};
            err_count_r          <= {CNT_W{1'b0}};
            err_flag_r           <= 1'b0;
            first_err_sel_r      <= 3'b000;
            first_err_expected_r <= {WIDTH{1'b0}};
            first_err_actual_r   <= {WIDTH{1'b0}};
        end else if (clear) begin
            chk_count_r          <= {CNT_W{1'b0}};
            err_count_r          <= {CNT_W{1'b0}};
            err_flag_r           <= 1'b0;
            first_err_sel_r      <= 3'b000;
            first_err_expected_r <= {WIDTH{1'b0}};
            first_err_actual_r   <= {WIDTH{1'b0}};
        end else if (cmp_en_s) begin
            if (chk_count_r != CNT_MAX) begin
                chk_count_r <= chk_count_r + CNT_ONE;
            end
            if (mismatch_s) begin
                if (err_count_r != CNT_MAX) begin
                    err_count_r <= err_count_r + CNT_ONE;
                end
                if (!err_flag_r) begin
                    first_err_sel_r      <= cmp_sel_s;
                    first_err_expected_r <= cmp_exp_s;
                    first_err_actual_r   <= bus.dut_result;
                end
                err_flag_r <= 1'b1;
            end
        end
    end

    assign chk_count          = chk_count_r;
    assign err_count          = err_count_r;
    assign err_flag           = err_flag_r;
    assign state              = state_r;
    assign first_err_sel      = first_err_sel_r;
    assign first_err_expected = first_err_expected_r;
    assign first_err_actual   = first_err_actual_r;
endmodule
